// File: rtl/rhs_frame_packer.sv
// rtl/rhs_frame_packer.sv - packs aligned RHS channel frames into magic-headed DMA packets
//
// Purpose: waits for a frame start (tuser) on the sample stream, emits a 64-bit
// magic header as two words, optionally a frame-count word, then forwards
// packet_length frames of NUM_CH words each and marks the final word with tlast.
// Optional feature: define RHS_FRAME_PACKER_FCNT_EN to insert the frame-count word.
//
// Ports:
//   aclk, areset                  clock; async active-high reset, release synchronised inside
//   enable                        start packets while high
//   packet_length[7:0]            frames per packet, 0 behaves as 1, latched at packet start
//   s_axis_tdata/tuser/tvalid/tready  channel word input, tuser marks channel 0
//   m_axis_tdata/tvalid/tready/tlast  packet output to DMA, registered
//   busy                          high whenever the packer is not idle
//   sync_err_cnt[15:0]            saturating count of misaligned frame starts
//   pkt_cnt[31:0]                 wrapping count of completed packets
`timescale 1ns/1ps

module rhs_frame_packer #(
    parameter int unsigned NUM_CH = 32,
    parameter logic [63:0] MAGIC  = 64'hC691199927021942
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        enable,
    input  logic [7:0]  packet_length,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic [15:0] sync_err_cnt,
    output logic [31:0] pkt_cnt
);

    localparam int unsigned       CW      = $clog2(NUM_CH);
    localparam logic [CW-1:0]     CH_LAST = CW'(NUM_CH - 1);

`ifdef RHS_FRAME_PACKER_FCNT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_HDR0, ST_HDR1, ST_FCNT, ST_DATA} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_HDR0, ST_HDR1, ST_DATA} state_t;
`endif

    // Reset synchroniser: asserts immediately, releases two clock edges later.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    state_t        state_q;
    logic [7:0]    len_q;
    logic [CW-1:0] ch_q;
    logic [7:0]    fr_q;
    logic          done_q;
    logic [31:0]   m_tdata_q;
    logic          m_tvalid_q;
    logic          m_tlast_q;
    logic [15:0]   sync_err_q;
    logic [31:0]   pkt_cnt_q;
`ifdef RHS_FRAME_PACKER_FCNT_EN
    logic [31:0]   frame_cnt_q;
`endif

    logic [7:0] len_d;
    logic       s_ready_d;
    logic       s_fire_d;
    logic       last_beat_d;
    logic       misaligned_d;

    assign len_d        = (packet_length == 8'd0) ? 8'd1 : packet_length;
    assign s_fire_d     = s_axis_tvalid && s_ready_d;
    assign last_beat_d  = (ch_q == CH_LAST) && (fr_q == len_q - 8'd1);
    assign misaligned_d = s_axis_tuser != (ch_q == '0);

    // In SYNC the frame-start word is refused so that DATA consumes it as
    // channel 0. In DATA, once the tlast word is loaded, input is held off
    // until that word leaves so the next frame stays on the input.
    always_comb begin
        s_ready_d = 1'b0;
        case (state_q)
            ST_SYNC: s_ready_d = !s_axis_tuser;
            ST_DATA: s_ready_d = !done_q && (!m_tvalid_q || m_axis_tready);
            default: s_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= 8'd1;
            ch_q        <= '0;
            fr_q        <= 8'd0;
            done_q      <= 1'b0;
            m_tdata_q   <= 32'd0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            sync_err_q  <= 16'd0;
            pkt_cnt_q   <= 32'd0;
`ifdef RHS_FRAME_PACKER_FCNT_EN
            frame_cnt_q <= 32'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        len_q   <= len_d;
                        state_q <= ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (s_axis_tvalid && s_axis_tuser) begin
                        m_tdata_q  <= MAGIC[31:0];
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b0;
                        ch_q       <= '0;
                        fr_q       <= 8'd0;
                        done_q     <= 1'b0;
                        state_q    <= ST_HDR0;
                    end
                end

                ST_HDR0: begin
                    if (m_axis_tready) begin
                        m_tdata_q <= MAGIC[63:32];
                        state_q   <= ST_HDR1;
                    end
                end

                ST_HDR1: begin
                    if (m_axis_tready) begin
`ifdef RHS_FRAME_PACKER_FCNT_EN
                        // No frames move between HDR0 and here, so this is
                        // the count as it stood at packet start.
                        m_tdata_q  <= frame_cnt_q;
                        state_q    <= ST_FCNT;
`else
                        m_tvalid_q <= 1'b0;
                        state_q    <= ST_DATA;
`endif
                    end
                end

`ifdef RHS_FRAME_PACKER_FCNT_EN
                ST_FCNT: begin
                    if (m_axis_tready) begin
                        m_tvalid_q <= 1'b0;
                        state_q    <= ST_DATA;
                    end
                end
`endif

                ST_DATA: begin
                    if (m_tvalid_q && m_axis_tready) begin
                        m_tvalid_q <= 1'b0;
                        if (m_tlast_q) begin
                            m_tlast_q <= 1'b0;
                            pkt_cnt_q <= pkt_cnt_q + 32'd1;
                            if (enable) begin
                                len_q   <= len_d;
                                state_q <= ST_SYNC;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    // A new word overrides the valid clear above.
                    if (s_fire_d) begin
                        m_tdata_q  <= s_axis_tdata;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= last_beat_d;
                        done_q     <= last_beat_d;
                        // Misaligned words are still forwarded; counters keep
                        // running so the packet length is unchanged.
                        if (misaligned_d && (sync_err_q != 16'hFFFF)) begin
                            sync_err_q <= sync_err_q + 16'd1;
                        end
                        if (ch_q == CH_LAST) begin
                            ch_q <= '0;
                            fr_q <= fr_q + 8'd1;
`ifdef RHS_FRAME_PACKER_FCNT_EN
                            frame_cnt_q <= frame_cnt_q + 32'd1;
`endif
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign s_axis_tready = s_ready_d;
    assign busy          = (state_q != ST_IDLE);
    assign sync_err_cnt  = sync_err_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_rhs_frame_packer.sv
// tb/tb_rhs_frame_packer.sv - randomized scoreboard bench for rhs_frame_packer
`timescale 1ns/1ps

module tb_rhs_frame_packer;

    localparam int          N   = 32;
    localparam logic [63:0] MAG = 64'hC691199927021942;
`ifdef RHS_FRAME_PACKER_FCNT_EN
    localparam int          F   = 1;
`else
    localparam int          F   = 0;
`endif

    logic        aclk          = 1'b0;
    logic        areset        = 1'b0;
    logic        enable        = 1'b0;
    logic [7:0]  packet_length = 8'd0;
    logic [31:0] s_tdata       = 32'd0;
    logic        s_tuser       = 1'b0;
    logic        s_tvalid      = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready      = 1'b0;
    logic        m_tlast;
    logic        busy;
    logic [15:0] sec;
    logic [31:0] pc;

    always #5 aclk = ~aclk;

    rhs_frame_packer dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .packet_length (packet_length),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .sync_err_cnt  (sec),
        .pkt_cnt       (pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Source stream and reference model state.
    logic [31:0] src_d[$];
    bit          src_u[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    int          exp_sync_err = 0;
    int          exp_pkts     = 0;
    int          frames_fwd   = 0;
    int          valid_pct    = 100;
    int          rdy_pct      = 100;
    bit          flush_req    = 0;

    // Model: junk (tuser=0) words before the frame start are dropped, the packet
    // is header + optional frame count + len*N words in input order, tlast on the
    // final word, and every word whose tuser disagrees with "channel 0" is an error.
    task automatic add_packet(input int len, input int junk, input int err_ch, input int err_fr);
        int          le;
        logic [31:0] d;
        bit          u;
        le = (len == 0) ? 1 : len;
        for (int j = 0; j < junk; j++) begin
            src_d.push_back($urandom);
            src_u.push_back(1'b0);
        end
        exp_d.push_back(MAG[31:0]);  exp_l.push_back(1'b0);
        exp_d.push_back(MAG[63:32]); exp_l.push_back(1'b0);
        if (F == 1) begin
            exp_d.push_back(32'(frames_fwd)); exp_l.push_back(1'b0);
        end
        for (int f = 0; f < le; f++) begin
            for (int c = 0; c < N; c++) begin
                d = $urandom;
                u = (c == 0);
                if (f == err_fr && c == err_ch) u = !u;
                src_d.push_back(d);
                src_u.push_back(u);
                exp_d.push_back(d);
                exp_l.push_back((f == le - 1) && (c == N - 1));
                if ((u != (c == 0)) && exp_sync_err < 65535) exp_sync_err++;
            end
        end
        frames_fwd += le;
        exp_pkts++;
    endtask

    // Input driver: random tvalid, holds a word until accepted.
    bit sfire;
    initial begin
        forever begin
            @(negedge aclk);
            sfire = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            if (flush_req) begin
                src_d.delete();
                src_u.delete();
                s_tvalid  = 1'b0;
                flush_req = 0;
            end else begin
                if (sfire && src_d.size() > 0) begin
                    void'(src_d.pop_front());
                    void'(src_u.pop_front());
                    s_tvalid = 1'b0;
                end
                if (!s_tvalid && src_d.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
                    s_tvalid = 1'b1;
                    s_tdata  = src_d[0];
                    s_tuser  = src_u[0];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_tready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Compare process: scoreboard on every accepted word, stability while stalled.
    logic [31:0] prev_d;
    logic        prev_l;
    bit          prev_stall    = 0;
    int          beat_in_pkt   = 0;
    int          last_pkt_beats = 0;
    logic [31:0] log_d[$];
    logic [31:0] ed;
    bit          el;

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall  = 0;
            beat_in_pkt = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1'b1);
                chk("stall_data", m_tdata, prev_d);
                chk("stall_last", m_tlast, prev_l);
            end
            if (m_tvalid && m_tready) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
                end else begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    chk("beat_data", m_tdata, ed);
                    chk("beat_last", m_tlast, el);
                end
                log_d.push_back(m_tdata);
                beat_in_pkt++;
                if (m_tlast) begin
                    last_pkt_beats = beat_in_pkt;
                    beat_in_pkt    = 0;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
        end
    end

    // Runs the queued packets: enable stays high until all but the last packet
    // has completed, then drops (optionally after 'keep' more cycles).
    task automatic run(input int keep, input int npk, input logic [7:0] next_len, input int pk_before);
        int t;
        enable = 1'b1;
        t = 0;
        while (!busy && t < 100) begin @(posedge aclk); #1; t++; end
        chk("start_busy", busy, 1'b1);
        repeat (5) @(posedge aclk);
        #1;
        packet_length = next_len;
        t = 0;
        while (pc != 32'(pk_before + npk - 1) && t < 20000) begin @(posedge aclk); #1; t++; end
        chk("pkt_wait_timeout", t < 20000, 1'b1);
        repeat (keep) @(posedge aclk);
        #1;
        enable = 1'b0;
        t = 0;
        while ((busy || exp_d.size() != 0) && t < 20000) begin @(posedge aclk); #1; t++; end
        chk("drain_timeout", t < 20000, 1'b1);
        chk("drain_left", exp_d.size(), 0);
        chk("idle_busy", busy, 1'b0);
        chk("pkt_cnt", pc, exp_pkts);
        chk("sync_err_cnt", sec, exp_sync_err);
    endtask

    int pb;
    int t;

    initial begin
        #2 areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sready", s_tready, 1'b0);
        chk("rst_sec", sec, 16'd0);
        chk("rst_pc", pc, 32'd0);
        areset = 1'b0;
        repeat (4) @(posedge aclk);
        #1;

        // Basic packet, full throughput.
        packet_length = 8'd4; rdy_pct = 100; valid_pct = 100;
        log_d.delete();
        pb = exp_pkts;
        add_packet(4, 0, -1, -1);
        run(0, 1, 8'd4, pb);
        chk("beat0_lit", log_d[0], 32'h27021942);
        chk("beat1_lit", log_d[1], 32'hC6911999);
        if (F == 1) chk("fcnt_lit", log_d[2], 32'd0);
        chk("beats_len4", last_pkt_beats, 130 + F);
        chk("pc_lit", pc, 32'd1);

        // Leading junk before the frame start.
        packet_length = 8'd1; valid_pct = 70;
        pb = exp_pkts;
        add_packet(1, 5, -1, -1);
        run(0, 1, 8'd1, pb);
        chk("junk_sec_lit", sec, 16'd0);

        // Backpressure.
        packet_length = 8'd2; rdy_pct = 50; valid_pct = 80;
        pb = exp_pkts;
        add_packet(2, 0, -1, -1);
        run(0, 1, 8'd2, pb);
        chk("beats_len2", last_pkt_beats, 66 + F);

        // Misaligned tuser at channel 7 of frame 1.
        pb = exp_pkts;
        add_packet(2, 0, 7, 1);
        run(0, 1, 8'd2, pb);
        chk("err_sec_lit", sec, 16'd1);
        chk("beats_err", last_pkt_beats, 66 + F);

        // Enable dropped during frame 1.
        packet_length = 8'd3; rdy_pct = 100; valid_pct = 100;
        pb = exp_pkts;
        add_packet(3, 0, -1, -1);
        run(40, 1, 8'd3, pb);
        chk("beats_len3", last_pkt_beats, 98 + F);

        // Back-to-back packets; length changed mid-packet applies to the next one.
        packet_length = 8'd2; rdy_pct = 60; valid_pct = 75;
        pb = exp_pkts;
        add_packet(2, 3, -1, -1);
        add_packet(0, 2, -1, -1);
        run(0, 2, 8'd0, pb);
        chk("beats_len0", last_pkt_beats, 34 + F);

        // Reset in the middle of DATA.
        packet_length = 8'd4; rdy_pct = 100; valid_pct = 100;
        log_d.delete();
        add_packet(4, 0, -1, -1);
        enable = 1'b1;
        t = 0;
        while (log_d.size() < 12 && t < 1000) begin @(posedge aclk); #1; t++; end
        chk("mid_wait_timeout", t < 1000, 1'b1);
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        chk("arst_tvalid", m_tvalid, 1'b0);
        chk("arst_tlast", m_tlast, 1'b0);
        chk("arst_tdata", m_tdata, 32'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_sready", s_tready, 1'b0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_sec", sec, 16'd0);
        enable = 1'b0;
        flush_req = 1;
        exp_d.delete();
        exp_l.delete();
        exp_pkts = 0; exp_sync_err = 0; frames_fwd = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("flush_done", flush_req, 1'b0);
        areset = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        packet_length = 8'd0;
        pb = exp_pkts;
        add_packet(0, 0, -1, -1);
        run(0, 1, 8'd0, pb);
        chk("beats_after_rst", last_pkt_beats, 34 + F);
        chk("pc_after_rst", pc, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
